// File: rtl/key_exp_multi.sv
// AES key expansion for 128/192/256-bit keys. It produces one schedule word per clock
// and one 128-bit round key, with a load strobe, every fourth clock.
module aes_sbox (
   input  logic [7:0] i_a,
   output logic [7:0] o_s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

   // The inverse is a^254, which maps 0 to 0. The affine transform follows it.
   assign w_x2   = gf_mul(i_a, i_a);
   assign w_x3   = gf_mul(w_x2, i_a);
   assign w_x6   = gf_mul(w_x3, w_x3);
   assign w_x12  = gf_mul(w_x6, w_x6);
   assign w_x15  = gf_mul(w_x12, w_x3);
   assign w_x30  = gf_mul(w_x15, w_x15);
   assign w_x60  = gf_mul(w_x30, w_x30);
   assign w_x120 = gf_mul(w_x60, w_x60);
   assign w_x240 = gf_mul(w_x120, w_x120);
   assign w_x252 = gf_mul(w_x240, w_x12);
   assign w_inv  = gf_mul(w_x252, w_x2);
   assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module key_exp_multi #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic                    mclk,
   input  logic                    arst_n,
   input  logic [0:MAX_KEY_BITS-1] ck_master,
   input  logic [1:0]              key_len,
   input  logic                    start,
   output logic [0:127]            rk,
   output logic [3:0]              rk_count,
   output logic                    rk_le,
   output logic                    busy,
   output logic                    key_err
);
   localparam int         MAX_NK  = MAX_KEY_BITS / 32;
   localparam logic [3:0] MAX_NK4 = 4'(MAX_NK);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t r_state, w_state_next;

   logic [31:0]  r_win [MAX_NK];
   logic [31:0]  w_kw [MAX_NK];
   logic [31:0]  w_load [MAX_NK];
   logic [5:0]   r_i, r_nwords, w_nwords_in;
   logic [2:0]   r_kidx;
   logic [3:0]   r_nk, w_nk_in, r_rk_count;
   logic [7:0]   r_rcon;
   logic [0:127] r_rk;
   logic         r_rk_le, r_key_err;
   logic         w_len_ok, w_accept, w_reject, w_step, w_last_kidx, w_emit;
   logic [31:0]  w_prev, w_old, w_rot, w_sub_in, w_sub, w_new;

   always_comb begin
      w_nk_in     = 4'd4;
      w_nwords_in = 6'd44;
      case (key_len)
         2'b01:   begin w_nk_in = 4'd6; w_nwords_in = 6'd52; end
         2'b10:   begin w_nk_in = 4'd8; w_nwords_in = 6'd60; end
         default: ;
      endcase
   end

   assign w_len_ok = (key_len != 2'b11) && (w_nk_in <= MAX_NK4);
   assign w_accept = (r_state == S_IDLE) && start && w_len_ok;
   assign w_reject = (r_state == S_IDLE) && start && !w_len_ok;
   assign w_step   = (r_state == S_RUN) && (r_i != r_nwords);
   assign w_emit   = w_step && (r_i[1:0] == 2'b11);

   always_ff @(posedge mclk or negedge arst_n) begin
      if (!arst_n) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_RUN;
         S_RUN:   if (r_i == r_nwords) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb busy = (r_state == S_RUN);

   generate
      for (genvar gi = 0; gi < MAX_NK; gi++) begin : g_kw
         assign w_kw[gi] = ck_master[32*gi +: 32];
      end
   endgenerate

   // At load time, key word k goes into slot Nk-1-k. The first Nk words then
   // come out of the oldest slot, which is the same slot that later supplies w[i-Nk].
   always_comb begin
      for (int s = 0; s < MAX_NK; s++) begin
         w_load[s] = '0;
         for (int k = 0; k < MAX_NK; k++)
            if (4'(k) == w_nk_in - 4'd1 - 4'(s)) w_load[s] = w_kw[k];
      end
   end

   always_comb begin
      w_old = '0;
      for (int k = 0; k < MAX_NK; k++)
         if (4'(k) == r_nk - 4'd1) w_old = r_win[k];
   end

   assign w_prev   = r_win[0];
   assign w_rot    = {w_prev[23:0], w_prev[31:24]};
   assign w_sub_in = (r_kidx == 3'd0) ? w_rot : w_prev;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (.i_a(w_sub_in[8*gi +: 8]), .o_s(w_sub[8*gi +: 8]));
      end
   endgenerate

   always_comb begin
      w_new = w_old ^ w_prev;
      if ({2'b00, r_nk} > r_i)                 w_new = w_old;
      else if (r_kidx == 3'd0)                 w_new = w_old ^ w_sub ^ {r_rcon, 24'h0};
      else if (r_nk == 4'd8 && r_kidx == 3'd4) w_new = w_old ^ w_sub;
   end

   assign w_last_kidx = (r_kidx == 3'(r_nk - 4'd1));

   always_ff @(posedge mclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < MAX_NK; k++) r_win[k] <= '0;
      end else if (w_accept) begin
         for (int k = 0; k < MAX_NK; k++) r_win[k] <= w_load[k];
      end else if (w_step) begin
         r_win[0] <= w_new;
         for (int k = 1; k < MAX_NK; k++) r_win[k] <= r_win[k-1];
      end
   end

   always_ff @(posedge mclk or negedge arst_n) begin
      if (!arst_n) begin
         r_i      <= '0;
         r_kidx   <= '0;
         r_nk     <= 4'd4;
         r_nwords <= 6'd44;
         r_rcon   <= 8'h01;
      end else if (w_accept) begin
         r_i      <= '0;
         r_kidx   <= '0;
         r_nk     <= w_nk_in;
         r_nwords <= w_nwords_in;
         r_rcon   <= 8'h01;
      end else if (w_step) begin
         r_i    <= r_i + 6'd1;
         r_kidx <= w_last_kidx ? 3'd0 : r_kidx + 3'd1;
         if (r_i >= {2'b00, r_nk} && r_kidx == 3'd0)
            r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
   end

   always_ff @(posedge mclk or negedge arst_n) begin
      if (!arst_n) begin
         r_rk       <= '0;
         r_rk_count <= '0;
         r_rk_le    <= 1'b0;
         r_key_err  <= 1'b0;
      end else begin
         r_rk_le   <= w_emit;
         r_key_err <= w_reject;
         if (w_emit) begin
            r_rk       <= {r_win[2], r_win[1], r_win[0], w_new};
            r_rk_count <= r_i[5:2];
         end
      end
   end

   assign rk       = r_rk;
   assign rk_count = r_rk_count;
   assign rk_le    = r_rk_le;
   assign key_err  = r_key_err;
endmodule

// File: tb/tb_key_exp_multi.sv
// Directed FIPS-197 vectors for key_exp_multi. The bench covers all three key sizes,
// rejected and ignored starts, reset in the middle of a run, and back-to-back runs.
module tb_key_exp_multi;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         arst_n;
   logic [0:255] ck_master;
   logic [1:0]   key_len;
   logic         start;
   logic [0:127] rk;
   logic [3:0]   rk_count;
   logic         rk_le, busy, key_err;

   logic [0:191] s_key;
   logic [1:0]   s_len;
   logic         s_start;
   logic [0:127] s_rk;
   logic [3:0]   s_cnt;
   logic         s_le, s_busy, s_kerr;

   key_exp_multi #(.MAX_KEY_BITS(256)) dut (
      .mclk(clk), .arst_n(arst_n), .ck_master(ck_master), .key_len(key_len), .start(start),
      .rk(rk), .rk_count(rk_count), .rk_le(rk_le), .busy(busy), .key_err(key_err));

   key_exp_multi #(.MAX_KEY_BITS(192)) dut192 (
      .mclk(clk), .arst_n(arst_n), .ck_master(s_key), .key_len(s_len), .start(s_start),
      .rk(s_rk), .rk_count(s_cnt), .rk_le(s_le), .busy(s_busy), .key_err(s_kerr));

   typedef struct {
      logic [1:0]   len;
      logic [0:255] key;
      bit           x_after;
      bit           inject;
      int           nr;
      int           ra;
      logic [0:127] rka;
      int           rb;
      logic [0:127] rkb;
   } vec_t;
   vec_t tv [4];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [0:127] cap_rk [16];
   int           cap_cnt [16];
   int           cap_cyc [16];
   int           cap_n = 0;
   bit           kerr_seen = 1'b0;
   int           e0s [4];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rk_le) begin
         if (cap_n < 16) begin
            cap_rk[cap_n]  = rk;
            cap_cnt[cap_n] = int'(rk_count);
            cap_cyc[cap_n] = cyc;
         end
         cap_n = cap_n + 1;
      end
      if (key_err) kerr_seen = 1'b1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_run(input int v, output int e0);
      int fall;
      int bad;
      cap_n = 0;
      kerr_seen = 1'b0;
      for (int j = 0; j < 16; j++) cap_rk[j] = 'x;
      key_len = tv[v].len;
      ck_master = tv[v].key;
      start = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      start = 1'b0;
      if (tv[v].x_after) ck_master = 'x;
      chk($sformatf("v%0d busy_at_accept", v), 128'(busy), 128'(1));
      fall = -1;
      for (int k = 0; k < 100 && fall < 0; k++) begin
         @(negedge clk);
         if (tv[v].inject && k == 10) begin
            start = 1'b1; key_len = 2'b10; ck_master = ~tv[v].key;
         end else if (tv[v].inject && k == 20) begin
            start = 1'b1; key_len = 2'b11;
         end else begin
            start = 1'b0;
         end
         #1;
         if (!busy) fall = cyc;
      end
      start = 1'b0;
      if (fall < 0) begin
         checks++; errors++;
         $display("FAIL v%0d busy_timeout: got busy=1 expected busy=0 within 100 cycles", v);
      end else begin
         chk($sformatf("v%0d busy_fall", v), 128'(fall - e0), 128'(4*(tv[v].nr+1)+1));
      end
      chk($sformatf("v%0d pulses", v), 128'(cap_n), 128'(tv[v].nr + 1));
      chk($sformatf("v%0d first_latency", v), 128'(cap_cyc[0] - e0), 128'(4));
      bad = 0;
      for (int j = 0; j < 16 && j < cap_n; j++) begin
         if (cap_cnt[j] != j) bad++;
         if (j > 0 && cap_cyc[j] - cap_cyc[j-1] != 4) bad++;
      end
      chk($sformatf("v%0d count_spacing_errors", v), 128'(bad), 128'(0));
      chk($sformatf("v%0d rk0", v), cap_rk[0], tv[v].key[0:127]);
      chk($sformatf("v%0d rk%0d", v, tv[v].ra), cap_rk[tv[v].ra], tv[v].rka);
      chk($sformatf("v%0d rk%0d", v, tv[v].rb), cap_rk[tv[v].rb], tv[v].rkb);
      chk($sformatf("v%0d no_key_err", v), 128'(kerr_seen), 128'(0));
   endtask

   initial begin
      int e;
      int n_before;
      bit hit;
      tv[0] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b1, 1'b0,
                12, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 12, 128'he98ba06f448c773c8ecc720401002202};
      tv[1] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0, 1'b0,
                14, 2, 128'h9ba354118e6925afa51a8b5f2067fcde, 14, 128'hfe4890d1e6188d0b046df344706c631e};
      tv[2] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b0,
                10, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tv[3] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b1,
                10, 2, 128'hf2c295f27a96b9435935807a7359f67f, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      arst_n = 1'b0; start = 1'b0; key_len = 2'b00; ck_master = '0;
      s_start = 1'b0; s_len = 2'b00; s_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); arst_n = 1'b1; #1;
      chk("reset rk", rk, 128'h0);
      chk("reset rk_count", 128'(rk_count), 128'(0));
      chk("reset rk_le", 128'(rk_le), 128'(0));
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset key_err", 128'(key_err), 128'(0));
      chk("reset busy192", 128'(s_busy), 128'(0));

      // The first instance sees the illegal code. The 192-bit instance sees a 256-bit request.
      @(negedge clk);
      key_len = 2'b11; start = 1'b1;
      s_len = 2'b10; s_start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; s_start = 1'b0;
      chk("rej11 key_err", 128'(key_err), 128'(1));
      chk("rej11 busy", 128'(busy), 128'(0));
      chk("rej256 key_err192", 128'(s_kerr), 128'(1));
      chk("rej256 busy192", 128'(s_busy), 128'(0));
      @(posedge clk); #1;
      chk("rej11 key_err_drop", 128'(key_err), 128'(0));
      chk("rej11 busy_after", 128'(busy), 128'(0));
      chk("rej256 key_err192_drop", 128'(s_kerr), 128'(0));
      chk("rej256 busy192_after", 128'(s_busy), 128'(0));
      @(negedge clk);
      s_len = 2'b01; s_key = tv[0].key[0:191]; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("acc192 busy192", 128'(s_busy), 128'(1));
      chk("acc192 key_err192", 128'(s_kerr), 128'(0));

      @(negedge clk);
      for (int v = 0; v < 4; v++) begin
         do_run(v, e0s[v]);
         $display("run %0d: key_len=%0d e0=%0d pulses=%0d", v, tv[v].len, e0s[v], cap_n);
         if (v > 0)
            chk($sformatf("v%0d back_to_back_gap", v), 128'(e0s[v] - e0s[v-1]),
                128'(4*(tv[v-1].nr+1)+2));
      end

      // Reset is applied in the cycle where the fifth strobe of an AES-128 run is high.
      cap_n = 0;
      key_len = 2'b00; ck_master = tv[2].key; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk); #1;
         if (cap_n >= 5) hit = 1'b1;
      end
      chk("midreset reached_5th", 128'(hit), 128'(1));
      chk("midreset rk_le_before", 128'(rk_le), 128'(1));
      arst_n = 1'b0; #1;
      chk("midreset rk", rk, 128'h0);
      chk("midreset rk_count", 128'(rk_count), 128'(0));
      chk("midreset rk_le", 128'(rk_le), 128'(0));
      chk("midreset busy", 128'(busy), 128'(0));
      n_before = cap_n;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk("midreset no_more_strobes", 128'(cap_n - n_before), 128'(0));
      chk("midreset busy_after", 128'(busy), 128'(0));
      $display("reset mid-run: strobes before reset=%0d", n_before);
      do_run(2, e);
      $display("run after reset: e0=%0d pulses=%0d", e, cap_n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end
endmodule
